chnnl_stim: RTL and testbench
=============================

CHNNL_STIM -- requirements
Module: chnnl_stim

Interface
REQ-001 clk  input  1  system clock; all state changes on posedge clk.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 start  input  1  request to run one stimulus sequence; sampled only in IDLE.
REQ-004 abort  input  1  terminate the sequence in progress.
REQ-005 cfg  input  5  event select; encoding: [4] pos edge, [3] neg edge, [2] high level, [1] low level, [0] don't care.
REQ-006 delay  input  16  idle cycles before each pulse, minus one.
REQ-007 width  input  16  active-phase length in cycles; 0 treated as 1.
REQ-008 reps  input  8  pulse count; 0 treated as 1.
REQ-009 busy  output  1  sequence in progress.
REQ-010 done  output  1  one-cycle completion strobe.
REQ-011 CH_H  output  1  emulated high-threshold comparator output.
REQ-012 CH_L  output  1  emulated low-threshold comparator output.

Function
REQ-013 States: IDLE, DELAY, ACTIVE, DONE; the state register is binary-encoded.
REQ-014 In IDLE, start=1 && abort=0 at edge k latches cfg/delay/width/reps, enters DELAY at k with counter=delay, and sets busy=1 from k.
REQ-015 Input changes while busy have no effect; start while busy is ignored and not queued.
REQ-016 Polarity select: highest set bit of cfg[4:1] wins; bit4/bit2 give idle level 0 and active level 1; bit3/bit1 give idle level 1 and active level 0.
REQ-017 Internal level lvl is driven to the latched idle level at edge k, and stays at idle level in DELAY and DONE.
REQ-018 DELAY: counter==0 -> ACTIVE at the next edge; otherwise decrement; DELAY lasts delay+1 cycles, so the first ACTIVE edge is k+delay+1.
REQ-019 ACTIVE: lvl = active level for W=max(width,1) cycles, then DELAY again (counter reloaded) if fewer than R=max(reps,1) pulses are done, else DONE.
REQ-020 DONE: exactly one cycle with done=1 and busy=0, then IDLE.
REQ-021 After completion, lvl holds the last idle level until the next accepted start or reset.
REQ-022 Slew emulation: lvl_q = lvl delayed one clk; CH_H = lvl AND lvl_q; CH_L = lvl OR lvl_q; rising crossings hit CH_L one cycle before CH_H, falling crossings hit CH_H one cycle before CH_L.
REQ-023 A W=1 active-high pulse pulses CH_L only (runt); CH_H stays 0. A W=1 active-low pulse dips CH_H only.
REQ-024 cfg[4:1]==0: a single DELAY pass (reps ignored), then DONE; lvl unchanged.
REQ-025 abort=1 in any non-IDLE state -> IDLE at the next edge; lvl goes to idle level, busy=0, done stays 0.
REQ-026 abort and start in the same IDLE cycle: abort wins, and the start is dropped.
REQ-027 Counters are 16-bit (delay/width) and 8-bit (reps), with no wrap; counting stops at 0.
REQ-028 Maximum sequence: delay=FFFF, width=FFFF, reps=FF; the block runs to completion without overflow.

Reset
REQ-029 rst_n=0 at an edge forces IDLE, lvl=0, lvl_q=0, busy=0, done=0, CH_H=0, CH_L=0, and clears all counters and latched configuration.
REQ-030 Reset mid-sequence takes effect at that edge, takes priority over start and abort, and produces no done.

Structure
REQ-031 A shared package holds the cfg bit-position constants (matching the channel-trigger encoding), the state enum typedef, and the counter widths.
REQ-032 One sub-module, chnnl_stim_cnt, implements the loadable 16-bit down-counter with a zero flag; it is instantiated for both delay and width.
REQ-033 All outputs are registered or built from registered lvl/lvl_q only; no combinational path runs from inputs to outputs.

Verification
REQ-034 Scenario 1: cfg=10000, delay=2, width=3, reps=1, start at edge k -> CH_L=1 at k+3..k+6, CH_H=1 at k+4..k+5, done=1 at k+6 only.
REQ-035 Scenario 2: cfg=01000, delay=0, width=2, reps=3 -> lvl high from k; 3 low dips of 2 cycles separated by 1 idle cycle; CH_H leads each fall; one done pulse.
REQ-036 Scenario 3: cfg=10000, width=0 -> runt: CH_L high 2 cycles, CH_H never rises.
REQ-037 Scenario 4: abort during the 2nd ACTIVE phase of reps=4 -> IDLE next edge, CH_H/CH_L return to 0 within 2 cycles, no done, busy=0.
REQ-038 Scenario 5: start re-pulsed while busy, then rst_n=0 mid-DELAY -> no second sequence; all outputs 0 at the reset edge.
REQ-039 Scenario 6: cfg=00001, delay=5 -> done at k+6, CH_H=CH_L=0 throughout.

Source files
------------

// File: rtl/chnnl_stim_pkg.sv
// Shared definitions for the channel stimulus generator: cfg bit positions,
// FSM state type, counter widths and the trigger-polarity decoder.
package chnnl_stim_pkg;

    localparam int CFG_W    = 5;
    localparam int CFG_POS  = 4;
    localparam int CFG_NEG  = 3;
    localparam int CFG_HIGH = 2;
    localparam int CFG_LOW  = 1;
    localparam int CFG_DC   = 0;

    localparam int CNT_W  = 16;
    localparam int REPS_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        logic idle_lvl;
    } pol_t;

    // Highest set select bit wins; edge and level variants of one polarity
    // drive the same idle/active levels.
    function automatic pol_t decode_pol(input logic [CFG_POS:CFG_LOW] sel);
        pol_t p;
        p.valid = |sel;
        if (sel[CFG_POS])       p.idle_lvl = 1'b0;
        else if (sel[CFG_NEG])  p.idle_lvl = 1'b1;
        else if (sel[CFG_HIGH]) p.idle_lvl = 1'b0;
        else if (sel[CFG_LOW])  p.idle_lvl = 1'b1;
        else                    p.idle_lvl = 1'b0;
        return p;
    endfunction

endpackage

// File: rtl/chnnl_stim_cnt.sv
// Loadable down-counter that saturates at zero and flags when it is there.
module chnnl_stim_cnt
    import chnnl_stim_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: registers use <= so every flop samples pre-edge values; the reset
    // is synchronous, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/chnnl_stim.sv
// Channel stimulus generator: emits delayed pulse trains on an internal level
// and presents it through a two-tap slew model as high/low comparator outputs.
module chnnl_stim
    import chnnl_stim_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CFG_W-1:0]  cfg,
    input  logic [CNT_W-1:0]  delay,
    input  logic [CNT_W-1:0]  width,
    input  logic [REPS_W-1:0] reps,
    output logic              busy,
    output logic              done,
    output logic              CH_H,
    output logic              CH_L
);

    state_t            state;
    logic              lvl;
    logic              lvl_q;
    logic              pol_valid;
    logic              idle_lvl;
    logic [CNT_W-1:0]  delay_q;
    logic [CNT_W-1:0]  width_q;
    logic [REPS_W-1:0] reps_left;

    pol_t              pol_in;
    logic              cfg_unused;
    logic              accept;

    logic              dly_load;
    logic              dly_dec;
    logic              dly_zero;
    logic [CNT_W-1:0]  dly_val;
    logic              wid_load;
    logic              wid_dec;
    logic              wid_zero;
    logic [CNT_W-1:0]  wid_val;

    assign pol_in     = decode_pol(cfg[CFG_POS:CFG_LOW]);
    assign cfg_unused = cfg[CFG_DC];
    assign accept     = (state == ST_IDLE) && start && !abort;

    // Both counters are loaded one edge ahead of the phase they time, so a
    // phase ends on the cycle its counter reads zero.
    always_comb begin
        dly_load = 1'b0;
        dly_dec  = 1'b0;
        dly_val  = delay_q;
        wid_load = 1'b0;
        wid_dec  = 1'b0;
        wid_val  = (width_q == '0) ? '0 : width_q - 1'b1;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    dly_load = 1'b1;
                    dly_val  = delay;
                end
            end
            ST_DELAY: begin
                dly_dec = 1'b1;
                if (dly_zero && pol_valid)
                    wid_load = 1'b1;
            end
            ST_ACTIVE: begin
                wid_dec = 1'b1;
                if (wid_zero && reps_left != '0)
                    dly_load = 1'b1;
            end
            default: ;
        endcase
    end

    chnnl_stim_cnt u_dly_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dly_load),
        .dec      (dly_dec),
        .load_val (dly_val),
        .zero     (dly_zero)
    );

    chnnl_stim_cnt u_wid_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wid_load),
        .dec      (wid_dec),
        .load_val (wid_val),
        .zero     (wid_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            lvl       <= 1'b0;
            lvl_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pol_valid <= 1'b0;
            idle_lvl  <= 1'b0;
            delay_q   <= '0;
            width_q   <= '0;
            reps_left <= '0;
        end else begin
            lvl_q <= lvl;
            done  <= 1'b0;
            if (state != ST_IDLE && abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                if (pol_valid)
                    lvl <= idle_lvl;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            state     <= ST_DELAY;
                            busy      <= 1'b1;
                            pol_valid <= pol_in.valid;
                            idle_lvl  <= pol_in.idle_lvl;
                            delay_q   <= delay;
                            width_q   <= width;
                            reps_left <= (reps == '0) ? '0 : reps - 1'b1;
                            if (pol_in.valid)
                                lvl <= pol_in.idle_lvl;
                        end
                    end
                    ST_DELAY: begin
                        if (dly_zero) begin
                            if (pol_valid) begin
                                state <= ST_ACTIVE;
                                lvl   <= ~idle_lvl;
                            end else begin
                                // No polarity selected: a pure timed wait.
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    ST_ACTIVE: begin
                        if (wid_zero) begin
                            lvl <= idle_lvl;
                            if (reps_left == '0) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state     <= ST_DELAY;
                                reps_left <= reps_left - 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Slew emulation: the high comparator needs two samples above threshold,
    // the low comparator trips on either.
    assign CH_H = lvl & lvl_q;
    assign CH_L = lvl | lvl_q;

endmodule

// File: tb/tb_chnnl_stim.sv
// Self-checking bench for chnnl_stim: a cycle-offset model of the pulse train
// checked every cycle, plus directed scenarios with hand-derived patterns.
module tb_chnnl_stim;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  cfg;
    logic [15:0] delay;
    logic [15:0] width;
    logic [7:0]  reps;
    logic        busy;
    logic        done;
    logic        ch_h;
    logic        ch_l;

    int n_tests = 0;
    int n_fail  = 0;

    chnnl_stim dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .cfg   (cfg),
        .delay (delay),
        .width (width),
        .reps  (reps),
        .busy  (busy),
        .done  (done),
        .CH_H  (ch_h),
        .CH_L  (ch_l)
    );

    always #5 clk = ~clk;

    // Model: a sequence accepted at cycle k is a pure function of offset o=c-k.
    int   cyc      = 0;
    bit   in_seq   = 1'b0;
    int   k_start  = 0;
    int   seq_len  = 0;
    int   period   = 1;
    int   d_m      = 0;
    bit   pol_m    = 1'b0;
    bit   idle_m   = 1'b0;
    logic m_lvl    = 1'b0;
    logic m_prev   = 1'b0;
    logic m_busy   = 1'b0;
    logic m_done   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input logic rv, input logic sv, input logic av,
                              input logic [4:0] cv, input logic [15:0] dv,
                              input logic [15:0] wv, input logic [7:0] rpv);
        int o;
        int w_eff;
        int r_eff;
        cyc++;
        m_prev = m_lvl;
        if (!rv) begin
            in_seq = 1'b0;
            m_lvl  = 1'b0;
            m_prev = 1'b0;
            m_busy = 1'b0;
            m_done = 1'b0;
        end else begin
            o = cyc - k_start;
            if (in_seq && o <= seq_len + 1) begin
                if (av || o == seq_len + 1) begin
                    in_seq = 1'b0;
                    m_busy = 1'b0;
                    m_done = 1'b0;
                    if (av && pol_m) m_lvl = idle_m;
                end else if (o == seq_len) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    if (pol_m) m_lvl = idle_m;
                end else begin
                    m_busy = 1'b1;
                    m_done = 1'b0;
                    if (pol_m) m_lvl = ((o % period) > d_m) ? ~idle_m : idle_m;
                end
            end else begin
                in_seq = 1'b0;
                m_busy = 1'b0;
                m_done = 1'b0;
                if (sv && !av) begin
                    k_start = cyc;
                    d_m     = int'(dv);
                    w_eff   = (wv == 16'd0) ? 1 : int'(wv);
                    r_eff   = (rpv == 8'd0) ? 1 : int'(rpv);
                    pol_m   = 1'b0;
                    idle_m  = 1'b0;
                    for (int b = 4; b >= 1; b--) begin
                        if (!pol_m && cv[b]) begin
                            pol_m  = 1'b1;
                            idle_m = (b == 3 || b == 1);
                        end
                    end
                    period  = d_m + 1 + w_eff;
                    seq_len = pol_m ? r_eff * period : d_m + 1;
                    in_seq  = 1'b1;
                    m_busy  = 1'b1;
                    if (pol_m) m_lvl = idle_m;
                end
            end
        end
    endtask

    task automatic step(input logic rv, input logic sv, input logic av,
                        input logic [4:0] cv, input logic [15:0] dv,
                        input logic [15:0] wv, input logic [7:0] rpv);
        rst_n = rv;
        start = sv;
        abort = av;
        cfg   = cv;
        delay = dv;
        width = wv;
        reps  = rpv;
        model_edge(rv, sv, av, cv, dv, wv, rpv);
        @(posedge clk);
        @(negedge clk);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("CH_H", ch_h, m_lvl & m_prev);
        check("CH_L", ch_l, m_lvl | m_prev);
    endtask

    task automatic idle_step();
        step(1'b1, 1'b0, 1'b0, 5'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
    endtask

    task automatic reset_step();
        step(1'b0, 1'($urandom), 1'($urandom), 5'($urandom), 16'($urandom),
             16'($urandom), 8'($urandom));
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset CH_H", ch_h, 1'b0);
        check("reset CH_L", ch_l, 1'b0);
    endtask

    // Hand-derived per-offset bit patterns (bit i = value after edge k+i).
    task automatic seq_lit(input string nm, input logic [4:0] cv, input logic [15:0] dv,
                           input logic [15:0] wv, input logic [7:0] rpv, input int n,
                           input logic [15:0] eb, input logic [15:0] ed,
                           input logic [15:0] eh, input logic [15:0] el);
        reset_step();
        for (int i = 0; i < n; i++) begin
            if (i == 0) step(1'b1, 1'b1, 1'b0, cv, dv, wv, rpv);
            else        idle_step();
            check({nm, " busy lit"}, busy, eb[i]);
            check({nm, " done lit"}, done, ed[i]);
            check({nm, " CH_H lit"}, ch_h, eh[i]);
            check({nm, " CH_L lit"}, ch_l, el[i]);
        end
    endtask

    initial begin
        int n_done;
        int done_at;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg   = '0;
        delay = '0;
        width = '0;
        reps  = '0;

        reset_step();
        reset_step();

        // Scenario 1: rising pulse, delay 2, width 3.
        seq_lit("s1", 5'b10000, 16'd2, 16'd3, 8'd1, 8,
                16'h003F, 16'h0040, 16'h0030, 16'h0078);
        // Scenario 2: active-low dips, three reps.
        seq_lit("s2", 5'b01000, 16'd0, 16'd2, 8'd3, 11,
                16'h01FF, 16'h0200, 16'h0400, 16'h06DB);
        // Scenario 3: width 0 gives a one-cycle runt.
        seq_lit("s3", 5'b10000, 16'd1, 16'd0, 8'd1, 6,
                16'h0007, 16'h0008, 16'h0000, 16'h000C);
        // Scenario 6: no polarity, pure wait.
        seq_lit("s6", 5'b00001, 16'd5, 16'd7, 8'd9, 9,
                16'h003F, 16'h0040, 16'h0000, 16'h0000);

        // Scenario 4: abort during the second active phase.
        reset_step();
        step(1'b1, 1'b1, 1'b0, 5'b10000, 16'd1, 16'd3, 8'd4);
        for (int i = 1; i < 8; i++) idle_step();
        check("s4 busy pre", busy, 1'b1);
        check("s4 CH_L pre", ch_l, 1'b1);
        step(1'b1, 1'b0, 1'b1, 5'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
        check("s4 busy abort", busy, 1'b0);
        check("s4 done abort", done, 1'b0);
        check("s4 CH_H abort", ch_h, 1'b0);
        idle_step();
        check("s4 CH_L settle", ch_l, 1'b0);
        check("s4 CH_H settle", ch_h, 1'b0);
        for (int i = 0; i < 12; i++) begin
            idle_step();
            check("s4 no done", done, 1'b0);
        end

        // Scenario 5: start re-pulsed while busy, then reset mid-delay.
        reset_step();
        step(1'b1, 1'b1, 1'b0, 5'b10000, 16'd10, 16'd2, 8'd1);
        for (int i = 1; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, 5'($urandom), 16'd0, 16'd1, 8'd1);
        check("s5 busy", busy, 1'b1);
        step(1'b0, 1'b1, 1'b0, 5'b10000, 16'd0, 16'd1, 8'd1);
        check("s5 rst busy", busy, 1'b0);
        check("s5 rst CH_L", ch_l, 1'b0);
        for (int i = 0; i < 20; i++) begin
            idle_step();
            check("s5 no seq busy", busy, 1'b0);
            check("s5 no seq done", done, 1'b0);
        end

        // Abort and start together in IDLE: start dropped.
        reset_step();
        step(1'b1, 1'b1, 1'b1, 5'b10000, 16'd0, 16'd1, 8'd1);
        check("s7 busy", busy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle_step();
            check("s7 CH_L", ch_l, 1'b0);
        end

        // Max repetition count with minimal timing: done lands at offset 255*2.
        reset_step();
        step(1'b1, 1'b1, 1'b0, 5'b00100, 16'd0, 16'd0, 8'd255);
        n_done  = 0;
        done_at = 0;
        for (int i = 1; i < 516; i++) begin
            idle_step();
            if (done === 1'b1) begin
                n_done++;
                done_at = i;
            end
        end
        check("max reps done count", n_done, 1);
        check("max reps done offset", done_at, 510);

        // Long counters.
        reset_step();
        step(1'b1, 1'b1, 1'b0, 5'b00010, 16'h0123, 16'h0100, 8'd2);
        for (int i = 1; i < 1110; i++) idle_step();

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 39) == 0),
                 5'($urandom),
                 16'($urandom_range(0, 4)),
                 16'($urandom_range(0, 4)),
                 8'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
